keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 hex matrix keypad and turns one debounced key press into a 4-bit hex code with a one-cycle valid strobe. It is the calculator's input-side counterpart to the seven-segment display path: the display path turns a hex nibble into pins, and this block turns pins back into a hex nibble. It sits between the board keypad header and the calculator operand/operator logic.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven; must be >= 4.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical frames needed to accept a press or a release; must be >= 1.
- `REPEAT_FRAMES`, default 100: auto-repeat period in frames; used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `col`  out  4  column drive, active-low; exactly one bit is low at any time.
- `row`  in  4  row sense, active-low, pulled up externally; asynchronous to `clk`.
- `key`  out  4  hex code of the accepted key; holds its value until the next accept.
- `key_valid`  out  1  one-cycle strobe; `key` is valid in the same cycle.
- `key_held`  out  1  level; high while the accepted key is debounced-pressed.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column scan:
  - The column index advances 0→1→2→3→0, one step every `SCAN_DIV` cycles.
  - `col` = ~(1 << index).
  - Synchronized rows are sampled on the last cycle of each column's dwell.
  - A frame is 4 dwells. Frame end is the sample taken in column 3.
- Per-frame candidate:
  - Exactly one pressed row/column intersection in the frame → candidate = code from the key map.
  - Zero presses, or two or more presses (ghosting or chords) → candidate = none.
- Key map, code at row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM, evaluated only at frame end:
  - IDLE:
    - Candidate present → store it, cnt=1, go to PRESS.
    - If `DEBOUNCE_FRAMES`=1, accept immediately and go to HELD.
  - PRESS:
    - Same candidate → cnt++. When cnt reaches `DEBOUNCE_FRAMES`: accept, go to HELD.
    - Different candidate → restart PRESS with the new code, cnt=1.
    - None → IDLE.
  - HELD:
    - None → cnt++. When cnt reaches `DEBOUNCE_FRAMES`: go to IDLE.
    - Any candidate → cnt=0.
    - A different key while HELD produces no new accept until release completes.
  - Accept = load `key`, pulse `key_valid`.
- `key_held` = 1 exactly when the state is HELD.
- Counter widths: $clog2 of the parameter +1. The frame counter saturates and never wraps.

## Timing
- Reset values: `col`=4'b1110, `key`=4'h0, `key_valid`=0, `key_held`=0, state IDLE, all counters 0.
- `rst` mid-scan or mid-press:
  - Next cycle shows the reset values.
  - No `key_valid` is emitted.
  - The synchronizer is cleared to 4'b1111.
- `col` changes on the clock edge after the last dwell cycle. Every column is driven for exactly `SCAN_DIV` cycles.
- The frame-end evaluation is registered. `key_valid`, `key`, and `key_held` update on the edge after the column-3 sample cycle.
- Minimum press-to-strobe latency: `DEBOUNCE_FRAMES` frames from the first frame containing the key, plus 1 cycle. Sync delay adds 2 cycles on the sense path.
- `key_valid` never stays high for two consecutive cycles.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a frame counter counts frames with the same accepted key.
  - Every `REPEAT_FRAMES` such frames, `key_valid` pulses again with an unchanged `key`.
  - The counter is cleared on entry to HELD and on any none/different frame.
- `KEYPAD_REPEAT_EN` undefined:
  - Exactly one `key_valid` per press.
  - Repeat logic is absent and `REPEAT_FRAMES` is ignored.

## Structure
- `keypad_pkg` holds:
  - the state enum typedef (IDLE, PRESS, HELD);
  - the 16-entry key-map constant, indexed {row, col};
  - the `NO_KEY` encoding for the candidate.
- Sub-module `keypad_col_scan`:
  - contains the synchronizer, dwell counter, column drive, and frame accumulation;
  - outputs the per-frame candidate (valid, code) and a one-cycle frame-end strobe.
- The top level holds the debounce FSM and the optional repeat logic.

## Test plan
Bench parameters: `SCAN_DIV`=8, `DEBOUNCE_FRAMES`=3, `REPEAT_FRAMES`=5. Frame = 32 cycles. The keypad model pulls row r low while `col` bit c is low.

- Reset, no key pressed → `col` cycles 1110, 1101, 1011, 0111, each for 8 cycles. `key_valid` stays 0; `key`=0.
- Key r2/c1 held stable → exactly one `key_valid` with `key`=4'h8 after the 3rd qualifying frame. `key_held`=1 until 3 empty frames after release.
- Key r0/c3 pressed for 2 frames, then released → no `key_valid` and state returns to IDLE.
- Keys r3/c0 and r3/c1 pressed together → candidate none and no strobe. Releasing r3/c1 → `key`=4'h0 strobe after 3 frames.
- Without `KEYPAD_REPEAT_EN`, key r1/c3 held for 20 frames → one strobe with `key`=4'hB. With the macro defined → strobe, then repeat strobes every 5 frames.
- `rst` asserted during PRESS → `col`=1110, all outputs 0 the next cycle, and no strobe for that press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } cand_t;

    // Indexed {row, col}
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    localparam cand_t NO_KEY = '{valid: 1'b0, code: 4'h0};

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and decoded-key bundle between the scanner and the keypad/calculator side.
interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (output col, output key, output key_valid, output key_held, input row);
    modport slave  (input col, input key, input key_valid, input key_held, output row);
endinterface

// File: rtl/keypad_col_scan.sv
// Column drive, row synchronizer and per-frame single-key candidate extraction.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       frame_end,
    output cand_t      cand
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] dwell;
    logic [1:0]    idx;
    logic [3:0]    row_s1, row_s2;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;

    logic          last;
    logic [3:0]    hit;
    logic [1:0]    hit_cnt;
    logic [1:0]    hit_row;
    logic [2:0]    sum;
    logic [1:0]    tot;
    logic [3:0]    code_nxt;

    // Press counts saturate at 2: anything above one key is just "none".
    always_comb begin
        last    = (dwell == '0);
        hit     = last ? ~row_s2 : 4'h0;
        hit_cnt = 2'd0;
        hit_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (hit[r]) begin
                hit_row = 2'(r);
                if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
            end
        end
        sum       = {1'b0, acc_cnt} + {1'b0, hit_cnt};
        tot       = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_nxt  = (hit_cnt == 2'd1) ? KEY_MAP[{hit_row, idx}] : acc_code;
        frame_end = last && (idx == 2'd3);
        cand      = (tot == 2'd1) ? '{valid: 1'b1, code: code_nxt} : NO_KEY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1   <= 4'hF;
            row_s2   <= 4'hF;
            dwell    <= DW'(SCAN_DIV - 1);
            idx      <= 2'd0;
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (last) begin
                dwell <= DW'(SCAN_DIV - 1);
                idx   <= idx + 2'd1;
                if (idx == 2'd3) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_cnt  <= tot;
                    acc_code <= code_nxt;
                end
            end else begin
                dwell <= dwell - 1'b1;
            end
        end
    end

    assign col = ~(4'b0001 << idx);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: debounce FSM (IDLE wait / PRESS qualify / HELD until release).
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 100
) (
    input logic               clk,
    input logic               rst,
    keypad_scanner_if.master  bus
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES) + 1;

    logic          frame_end;
    cand_t         cand;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]    pend, pend_nxt;
    logic [3:0]    key_r, key_nxt;
    logic          valid_r, valid_nxt;

    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk       (clk),
        .rst       (rst),
        .row       (bus.row),
        .col       (bus.col),
        .frame_end (frame_end),
        .cand      (cand)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES) + 1;
    logic [RW-1:0] rpt, rpt_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        key_nxt   = key_r;
        valid_nxt = 1'b0;
        cnt_inc   = (cnt == CW'(DEBOUNCE_FRAMES)) ? cnt : cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
        rpt_nxt   = rpt;
`endif
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (cand.valid) begin
                        pend_nxt = cand.code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            key_nxt   = cand.code;
                            valid_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = HELD;
                        end else begin
                            cnt_nxt   = CW'(1);
                            state_nxt = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (!cand.valid) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (cand.code == pend) begin
                        if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
                            key_nxt   = pend;
                            valid_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = HELD;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        pend_nxt = cand.code;
                        cnt_nxt  = CW'(1);
                    end
                end
                HELD: begin
                    // Here cnt counts consecutive empty frames toward release.
                    if (!cand.valid) begin
                        if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (cand.valid && cand.code == key_r) begin
                        if (rpt + 1'b1 == RW'(REPEAT_FRAMES)) begin
                            valid_nxt = 1'b1;
                            rpt_nxt   = '0;
                        end else begin
                            rpt_nxt = rpt + 1'b1;
                        end
                    end else begin
                        rpt_nxt = '0;
                    end
`endif
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state != HELD) rpt_nxt = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= 4'h0;
            key_r   <= 4'h0;
            valid_r <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            key_r   <= key_nxt;
            valid_r <= valid_nxt;
`ifdef KEYPAD_REPEAT_EN
            rpt     <= rpt_nxt;
`endif
        end
    end

    assign bus.key       = key_r;
    assign bus.key_valid = valid_r;
    assign bus.key_held  = (state == HELD);

endmodule
